// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the dual-issue register file.
package reg_file_pkg;
    localparam int REG_COUNT = 32;
    localparam int REG_W     = 32;
    localparam int ADDR_W    = 5;

    typedef logic [REG_W-1:0]  word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one combinational read port with write-through forwarding and zero-register detect.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  logic  rst,
    input  addr_t addr,
    input  word_t word,
    input  logic  we1,
    input  addr_t wa1,
    input  word_t wd1,
    input  logic  we2,
    input  addr_t wa2,
    input  word_t wd2,
    output word_t rd
);
    logic hit1;
    logic hit2;

    always_comb begin
        hit1 = we1 && (wa1 == addr);
        hit2 = we2 && (wa2 == addr);
        // Reset is tested first so X on the write ports cannot leak through.
        rd   = (rst || addr == ZERO_REG) ? '0 : hit2 ? wd2 : hit1 ? wd1 : word;
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 architectural register file, four async read ports, two sync write ports.
module reg_file
    import reg_file_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WE1,
    input  logic              WE2,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [ADDR_W-1:0] WA2,
    input  logic [REG_W-1:0]  WD1,
    input  logic [REG_W-1:0]  WD2,
    input  logic [ADDR_W-1:0] A11,
    input  logic [ADDR_W-1:0] A21,
    input  logic [ADDR_W-1:0] A12,
    input  logic [ADDR_W-1:0] A22,
    output logic [REG_W-1:0]  RD11,
    output logic [REG_W-1:0]  RD21,
    output logic [REG_W-1:0]  RD12,
    output logic [REG_W-1:0]  RD22
);
    word_t [REG_COUNT-1:0] regs_q;
    word_t [REG_COUNT-1:0] regs_d;
    addr_t [3:0]           ra;
    word_t [3:0]           rd;

    // Slot 2 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (WE1 && WA1 != ZERO_REG) regs_d[WA1] = WD1;
        if (WE2 && WA2 != ZERO_REG) regs_d[WA2] = WD2;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    assign ra = {A22, A12, A21, A11};
    assign {RD22, RD12, RD21, RD11} = rd;

    for (genvar i = 0; i < 4; i++) begin : g_rp
        reg_file_read_port u_rp (
            .rst  (Reset),
            .addr (ra[i]),
            .word (regs_q[ra[i]]),
            .we1  (WE1),
            .wa1  (WA1),
            .wd1  (WD1),
            .we2  (WE2),
            .wa2  (WA2),
            .wd2  (WD2),
            .rd   (rd[i])
        );
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plus random check of reg_file against an array-based reference model.
module tb_reg_file;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        WE1, WE2;
    logic [4:0]  WA1, WA2, A11, A21, A12, A22;
    logic [31:0] WD1, WD2;
    logic [31:0] RD11, RD21, RD12, RD22;

    logic [31:0] mdl [32];
    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .Clk(Clk), .Reset(Reset),
        .WE1(WE1), .WE2(WE2), .WA1(WA1), .WA2(WA2), .WD1(WD1), .WD2(WD2),
        .A11(A11), .A21(A21), .A12(A12), .A22(A22),
        .RD11(RD11), .RD21(RD21), .RD12(RD12), .RD22(RD22)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (Reset !== 1'b0 || a == 5'd0) return 32'd0;
        if (WE2 && WA2 == a) return WD2;
        if (WE1 && WA1 == a) return WD1;
        return mdl[a];
    endfunction

    task automatic check_all(input string ph);
        chk({ph, "_rd11"}, RD11, exp_rd(A11));
        chk({ph, "_rd21"}, RD21, exp_rd(A21));
        chk({ph, "_rd12"}, RD12, exp_rd(A12));
        chk({ph, "_rd22"}, RD22, exp_rd(A22));
    endtask

    task automatic drive(input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic we2, input logic [4:0] wa2, input logic [31:0] wd2,
                         input logic [4:0] a11, input logic [4:0] a21,
                         input logic [4:0] a12, input logic [4:0] a22);
        WE1 = we1; WA1 = wa1; WD1 = wd1;
        WE2 = we2; WA2 = wa2; WD2 = wd2;
        A11 = a11; A21 = a21; A12 = a12; A22 = a22;
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset === 1'b0) begin
            if (WE1 && WA1 != 5'd0) mdl[WA1] = WD1;
            if (WE2 && WA2 != 5'd0) mdl[WA2] = WD2;
        end
        #1;
    endtask

    task automatic cyc(input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic we2, input logic [4:0] wa2, input logic [31:0] wd2,
                       input logic [4:0] a11, input logic [4:0] a21,
                       input logic [4:0] a12, input logic [4:0] a22);
        drive(we1, wa1, wd1, we2, wa2, wd2, a11, a21, a12, a22);
        #2;
        check_all("pre");
        tick();
        check_all("post");
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    endfunction

    initial begin
        foreach (mdl[i]) mdl[i] = 32'd0;
        Reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd3, 5'd31);
        #1;
        check_all("rst");
        @(negedge Clk);
        Reset = 1'b0;
        for (int a = 0; a < 32; a++)
            cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(a), 5'(a), 5'(a));

        cyc(1'b1, 5'd1, 32'h6969FFFF, 1'b1, 5'd2, 32'hAAAAAAAA, 5'd0, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 5'd3, 32'h42042069, 1'b1, 5'd4, 32'h33229999, 5'd0, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd3, 5'd4);
        chk("wb_rd11", RD11, 32'h6969FFFF);
        chk("wb_rd21", RD21, 32'hAAAAAAAA);
        chk("wb_rd12", RD12, 32'h42042069);
        chk("wb_rd22", RD22, 32'h33229999);

        cyc(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5, 5'd5, 5'd5);
        chk("coll_fwd", RD11, 32'h22222222);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd1, 5'd5, 5'd2);
        chk("coll_store", RD12, 32'h22222222);

        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        #2;
        chk("zero_pre", RD11, 32'd0);
        tick();
        chk("zero_post", RD11, 32'd0);
        check_all("zero");

        cyc(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 5'd0, 5'd7);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd1, 5'd2, 5'd7);
        #2;
        chk("fwd_pre", RD22, 32'hDEADBEEF);
        chk("fwd_other", RD21, 32'h6969FFFF);
        tick();
        chk("fwd_post", RD22, 32'hDEADBEEF);
        check_all("fwd");

        drive(1'bx, 5'bx, 32'bx, 1'bx, 5'bx, 32'bx, 5'd1, 5'd2, 5'd3, 5'd4);
        #2;
        Reset = 1'b1;
        foreach (mdl[i]) mdl[i] = 32'd0;
        #1;
        chk("arst_rd11", RD11, 32'd0);
        chk("arst_rd21", RD21, 32'd0);
        chk("arst_rd12", RD12, 32'd0);
        chk("arst_rd22", RD22, 32'd0);
        tick();
        check_all("arst_edge");
        @(negedge Clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd3, 5'd4);
        Reset = 1'b0;
        #1;
        chk("post_rst_rd11", RD11, 32'd0);
        chk("post_rst_rd21", RD21, 32'd0);
        chk("post_rst_rd12", RD12, 32'd0);
        chk("post_rst_rd22", RD22, 32'd0);
        cyc(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'd0, 5'd9, 5'd1, 5'd0, 5'd9);
        chk("first_write", RD11, 32'h12345678);

        for (int n = 0; n < 500; n++)
            cyc(1'($urandom), rnd_addr(), $urandom, 1'($urandom), rnd_addr(), $urandom,
                rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
